vga_tile_scanner: RTL and testbench

Raster timing generator for the pong display path. It divides the system clock into a pixel-rate enable and runs 640x480@60 horizontal/vertical counters. It drives active-low sync pulses and a video-enable, and maps the beam position onto the 40x30 grid of 16x16-pixel tiles. Its `counter_x`/`counter_y` outputs feed the ball, paddle and renderer stages directly.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/pix_tick_gen.sv | 41 ++++
 rtl/vga_tile_scanner.sv | 117 +++++++++++
 tb/tb_vga_tile_scanner.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 raster constants for the pong display path.
// Used by the tile scanner and by the ball, paddle and renderer stages.
//   CLK_DIV            system clocks per pixel (100 MHz -> 25 MHz)
//   H_* / V_*          horizontal (pixels) and vertical (lines) timing
//   H_TOTAL / V_TOTAL  full line / frame lengths
//   TILE_SHIFT         log2 of the tile edge in pixels (16x16 tiles)
//   TILE_BLANK         tile code driven during blanking
//   GRID_COLS/ROWS     visible tile grid size (40x30)
package vga_pkg;

  localparam int CLK_DIV    = 4;

  localparam int H_VISIBLE  = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE  = 480;
  localparam int V_FP       = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;
  localparam int V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int TILE_SHIFT = 4;
  localparam int GRID_COLS  = H_VISIBLE >> TILE_SHIFT;
  localparam int GRID_ROWS  = V_VISIBLE >> TILE_SHIFT;

  // Outside every game object's column/row range, so blanking never hits.
  localparam logic [5:0] TILE_BLANK = 6'h3F;

  typedef logic [9:0] coord_t;
  typedef logic [5:0] tile_t;

  // Tile index of a beam coordinate.
  function automatic tile_t tile_of(input coord_t c, input int shift);
    coord_t s;
    s = c >> shift;
    return s[5:0];
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// pix_tick_gen: divides clk into a one-cycle pixel enable.
//   clk       system clock
//   rst       synchronous active-low reset
//   pix_tick  high for one clk every CLK_DIV clocks (when the divider is at CLK_DIV-1)
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_reg;
  logic [DW-1:0] div_next;
  logic          tick_reg;

  always_comb begin
    div_next = div_reg + 1'b1;
    if (div_reg == DIV_LAST) begin
      div_next = '0;
    end
  end

  // The tick is registered from the next divider value so it is high in
  // exactly the cycles where the divider sits at its last count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      div_reg  <= div_next;
      tick_reg <= (div_next == DIV_LAST);
    end
  end

  assign pix_tick = tick_reg;

endmodule

// File: rtl/vga_tile_scanner.sv
// vga_tile_scanner: 640x480@60 raster timing with tile-grid mapping.
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   pix_tick     one-clk pixel enable; counters advance on the edge ending it
//   pix_x/pix_y  beam position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   hsync/vsync  active-low sync pulses
//   video_on     beam inside the visible area
//   counter_x/y  tile column/row, or TILE_BLANK outside the visible area
//   frame_start  one-clk pulse when the beam wraps to (0,0)
module vga_tile_scanner #(
  parameter int CLK_DIV    = vga_pkg::CLK_DIV,
  parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int TILE_SHIFT = vga_pkg::TILE_SHIFT
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [5:0] counter_x,
  output logic [5:0] counter_y,
  output logic       frame_start
);

  import vga_pkg::*;

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       tick;
  coord_t     x_reg, x_next;
  coord_t     y_reg, y_next;
  logic       hsync_reg, vsync_reg, video_on_reg, frame_start_reg;
  tile_t      cx_reg, cy_reg;
  logic       video_on_next;
  logic       frame_wrap;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (tick)
  );

  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    frame_wrap = 1'b0;
    if (tick) begin
      if (x_reg == H_LAST) begin
        x_next = '0;
        if (y_reg == V_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = y_reg + 10'd1;
        end
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
  end

  assign video_on_next = (x_next < H_VIS) && (y_next < V_VIS);

  // Decode from the next counter values so sync/tile outputs change on the
  // same edge as pix_x/pix_y instead of one clock later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_reg           <= '0;
      y_reg           <= '0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      video_on_reg    <= 1'b1;
      cx_reg          <= '0;
      cy_reg          <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      hsync_reg       <= !((x_next >= HS_START) && (x_next < HS_END));
      vsync_reg       <= !((y_next >= VS_START) && (y_next < VS_END));
      video_on_reg    <= video_on_next;
      cx_reg          <= video_on_next ? tile_of(x_next, TILE_SHIFT) : TILE_BLANK;
      cy_reg          <= video_on_next ? tile_of(y_next, TILE_SHIFT) : TILE_BLANK;
      frame_start_reg <= frame_wrap;
    end
  end

  assign pix_tick    = tick;
  assign pix_x       = x_reg;
  assign pix_y       = y_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign counter_x   = cx_reg;
  assign counter_y   = cy_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_tile_scanner.sv
// tb_vga_tile_scanner: randomized-reset sweep of two scanner instances
// (full 640x480 timing and a shrunken raster that wraps whole frames quickly)
// against an arithmetic model: after k clocks out of reset the beam has
// seen floor(k/CLK_DIV) pixels, from which every output follows directly.
module tb_vga_tile_scanner;

  // Shrunken raster: 96 pixels x 41 lines, 3 clk per pixel -> 11808 clk/frame.
  localparam int S_DIV = 3;
  localparam int S_HV = 64, S_HF = 8, S_HS = 12, S_HB = 12;
  localparam int S_VV = 32, S_VF = 3, S_VS = 2, S_VB = 4;
  localparam int S_TS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       a_tick, a_hs, a_vs, a_von, a_fs;
  logic [9:0] a_x, a_y;
  logic [5:0] a_cx, a_cy;
  logic       b_tick, b_hs, b_vs, b_von, b_fs;
  logic [9:0] b_x, b_y;
  logic [5:0] b_cx, b_cy;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint k = 0;
  int     fs_seen = 0;

  always #5 clk = ~clk;

  vga_tile_scanner dut (
    .clk(clk), .rst(rst), .pix_tick(a_tick), .pix_x(a_x), .pix_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
    .counter_x(a_cx), .counter_y(a_cy), .frame_start(a_fs)
  );

  vga_tile_scanner #(
    .CLK_DIV(S_DIV), .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .TILE_SHIFT(S_TS)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_tick(b_tick), .pix_x(b_x), .pix_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
    .counter_x(b_cx), .counter_y(b_cy), .frame_start(b_fs)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s at k=%0d: got %0d, expected %0d", tag, k, got, exp);
    end
  endtask

  // Expected outputs for a raster after k clocks out of reset.
  task automatic model(input longint kk, input int d,
                       input int hv, input int hf, input int hs, input int hb,
                       input int vv, input int vf, input int vs, input int vb, input int ts,
                       output int x, output int y, output int tick, output int hsn,
                       output int vsn, output int von, output int fs,
                       output int cx, output int cy);
    longint p, ht, vt;
    ht   = hv + hf + hs + hb;
    vt   = vv + vf + vs + vb;
    p    = kk / d;
    x    = int'(p % ht);
    y    = int'((p / ht) % vt);
    tick = ((kk % d) == d - 1) ? 1 : 0;
    hsn  = (x >= hv + hf && x < hv + hf + hs) ? 0 : 1;
    vsn  = (y >= vv + vf && y < vv + vf + vs) ? 0 : 1;
    von  = (x < hv && y < vv) ? 1 : 0;
    fs   = (kk > 0 && (kk % d) == 0 && (p % (ht * vt)) == 0) ? 1 : 0;
    cx   = von ? (x >> ts) : 63;
    cy   = von ? (y >> ts) : 63;
  endtask

  task automatic compare_all();
    int x, y, t, hsn, vsn, von, fs, cx, cy;
    model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 4, x, y, t, hsn, vsn, von, fs, cx, cy);
    check_eq("a.pix_x", 32'(a_x), x);
    check_eq("a.pix_y", 32'(a_y), y);
    check_eq("a.pix_tick", 32'(a_tick), t);
    check_eq("a.hsync", 32'(a_hs), hsn);
    check_eq("a.vsync", 32'(a_vs), vsn);
    check_eq("a.video_on", 32'(a_von), von);
    check_eq("a.frame_start", 32'(a_fs), fs);
    check_eq("a.counter_x", 32'(a_cx), cx);
    check_eq("a.counter_y", 32'(a_cy), cy);
    model(k, S_DIV, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_TS,
          x, y, t, hsn, vsn, von, fs, cx, cy);
    check_eq("s.pix_x", 32'(b_x), x);
    check_eq("s.pix_y", 32'(b_y), y);
    check_eq("s.pix_tick", 32'(b_tick), t);
    check_eq("s.hsync", 32'(b_hs), hsn);
    check_eq("s.vsync", 32'(b_vs), vsn);
    check_eq("s.video_on", 32'(b_von), von);
    check_eq("s.frame_start", 32'(b_fs), fs);
    check_eq("s.counter_x", 32'(b_cx), cx);
    check_eq("s.counter_y", 32'(b_cy), cy);
    if (b_fs === 1'b1) fs_seen++;
  endtask

  // One clock: advance the model with the reset value the edge samples,
  // then compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rst) k = 0;
    else      k = k + 1;
    @(negedge clk);
    compare_all();
  endtask

  task automatic segment(input int seg, input int rst_len, input int run_len);
    int fs0;
    fs0 = fs_seen;
    rst = 1'b0;
    for (int i = 0; i < rst_len; i++) step();
    rst = 1'b1;
    for (int i = 0; i < run_len; i++) step();
    $display("seg %0d: reset %0d clk, run %0d clk, end a=(%0d,%0d) s=(%0d,%0d), frame pulses %0d",
             seg, rst_len, run_len, a_x, a_y, b_x, b_y, fs_seen - fs0);
  endtask

  initial begin
    @(negedge clk);
    // Power-up: 5 reset clocks then just over two shrunken frames.
    segment(0, 5, 26000);
    // Random mid-frame resets at arbitrary divider phases.
    for (int s = 1; s <= 3; s++)
      segment(s, int'($urandom_range(1, 4)), int'($urandom_range(200, 5000)));
    // After a mid-frame reset the frame timing restarts from scratch.
    segment(4, int'($urandom_range(1, 4)), 12500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
